board_renderer: RTL and testbench
=================================

// Module: board_renderer
// PURPOSE
//  Reader side of the board state: scans the 230-bit stacked-tile vector and the falling-piece
//  coordinates, then emits one pixel per clock to the VGA adapter (x, y, colour, plot).
//  Sits between the game FSM (issues start once per frame) and the VGA adapter.
//  A snapshot is taken at start, so each frame is self-consistent while the board keeps updating.
// PARAMETERS
//  TILE_PX      4     pixels per tile edge (power of 2, 1..8)
//  HIDDEN_ROWS  3     top board rows (0..HIDDEN_ROWS-1) not drawn
//  X_ORIGIN     40    screen x of column 0, pixel 0
//  Y_ORIGIN     10    screen y of first visible row, pixel 0
//  COL_EMPTY    3'b000 colour of empty tile
//  COL_STACK    3'b111 colour of stacked tile
//  COL_FALL     3'b110 colour of falling-piece tile
// PORTS
//  clk_50       in   1    system clock, all logic on posedge
//  reset        in   1    asynchronous, active-high reset
//  start        in   1    frame request; sampled only in IDLE
//  board_value  in   230  stacked tiles; row r occupies [r*10+:10]; col c is bit r*10+9-c
//  t0_x..t3_x   in   4    falling-piece columns (0..9)
//  t0_y..t3_y   in   5    falling-piece rows (0..22)
//  vga_x        out  8    pixel x
//  vga_y        out  7    pixel y
//  colour       out  3    pixel colour
//  plot         out  1    pixel valid/write strobe
//  busy         out  1    high from the cycle after start is accepted until done
//  done         out  1    one-cycle pulse after the last pixel
// BEHAVIOUR
//  Reset: state=IDLE, vga_x=0, vga_y=0, colour=0, plot=0, busy=0, done=0, counters=0.
//  Reset mid-frame aborts immediately: no further plots, and the next frame needs a new start.
//  FSM:
//   IDLE -start-> LATCH: capture board_value and all 8 coordinates into snapshot registers.
//   LATCH -> DRAW: clear counters row=HIDDEN_ROWS, col=0, py=0, px=0.
//   DRAW: one pixel per cycle. px increments first, then py, then col (0..9), then row (..22).
//   DRAW -> DONE after pixel (row 22, col 9, py=px=TILE_PX-1) is issued.
//   DONE: done=1 for one cycle -> IDLE.
//  Counter sweep and pixel count:
//   Inner order gives tile-by-tile raster: all TILE_PX^2 pixels of a tile, then the next column.
//   Pixels per frame = (23-HIDDEN_ROWS)*10*TILE_PX^2 = 3200 at defaults.
//  Output timing:
//   Outputs are registered, one cycle behind the counters.
//   plot is high exactly 3200 consecutive cycles per frame; the first plot is 2 cycles after start.
//   done is asserted in the cycle after the last plot.
//  Pixel address:
//   vga_x = X_ORIGIN + col*TILE_PX + px
//   vga_y = Y_ORIGIN + (row-HIDDEN_ROWS)*TILE_PX + py
//   Both are truncated to the port widths; no clipping is applied.
//  Colour priority: COL_FALL if (row,col) equals any snapshot (tk_y,tk_x); else COL_STACK if the
//   snapshot bit is 1; else COL_EMPTY.
//  Falling tiles with tk_y < HIDDEN_ROWS are not drawn. Coordinates out of range (x>9, y>22)
//   never match and are ignored.
//  start asserted while busy or in DONE is ignored (no queueing).
//  start held high continuously gives back-to-back frames, with IDLE lasting one cycle between.
//  busy=1 in LATCH, DRAW and DONE.
// TESTING
//  T1 zero board, coordinates parked at y=0, start pulse ->
//     3200 plots, all colour 000; first pixel (40,10), last (79,89); done 1 cycle after last plot.
//  T2 board bit 229 set (row 22, col 0) ->
//     16 pixels x 40..43, y 86..89 colour 111; all other pixels 000.
//  T3 stacked bit at row 3 col 9 (bit 30), and t0=(x9,y3) ->
//     pixels x 76..79, y 10..13 colour 110 (falling overrides stacked).
//  T4 piece entirely in rows 0..2 ->
//     no 110 pixels; board_value changed mid-frame does not alter the output (snapshot held).
//  T5 start pulsed again at the 100th plot ->
//     ignored, exactly 3200 plots and one done. Reset at the 500th plot ->
//     plot=0 and busy=0 the same cycle, no done, outputs hold reset values.
//  T6 start held high for 2 frames ->
//     2x3200 plots, 2 done pulses, 2 non-plot cycles (DONE, IDLE) + LATCH between frames.

Source files
------------

// File: rtl/board_renderer_if.sv
// Pixel-stream bundle between the frame requester / board source and the renderer.
// The master side drives the frame request, board snapshot source and piece coordinates.
// The slave side (the renderer) drives the VGA pixel stream and frame status.
interface board_renderer_if;
  logic         start;
  logic [229:0] board_value;
  logic [3:0]   t0_x;
  logic [3:0]   t1_x;
  logic [3:0]   t2_x;
  logic [3:0]   t3_x;
  logic [4:0]   t0_y;
  logic [4:0]   t1_y;
  logic [4:0]   t2_y;
  logic [4:0]   t3_y;
  logic [7:0]   vga_x;
  logic [6:0]   vga_y;
  logic [2:0]   colour;
  logic         plot;
  logic         busy;
  logic         done;

  modport master (
    output start, board_value,
    output t0_x, t1_x, t2_x, t3_x,
    output t0_y, t1_y, t2_y, t3_y,
    input  vga_x, vga_y, colour, plot, busy, done
  );

  modport slave (
    input  start, board_value,
    input  t0_x, t1_x, t2_x, t3_x,
    input  t0_y, t1_y, t2_y, t3_y,
    output vga_x, vga_y, colour, plot, busy, done
  );
endinterface

// File: rtl/board_renderer.sv
// Board renderer: snapshots the stacked-tile board and falling-piece coordinates on
// start, then sweeps every visible tile pixel by pixel (tile-by-tile raster) and emits
// one registered pixel per clock to the VGA adapter, ending with a one-cycle done pulse.
module board_renderer #(
  parameter int         TILE_PX     = 4,
  parameter int         HIDDEN_ROWS = 3,
  parameter int         X_ORIGIN    = 40,
  parameter int         Y_ORIGIN    = 10,
  parameter logic [2:0] COL_EMPTY   = 3'b000,
  parameter logic [2:0] COL_STACK   = 3'b111,
  parameter logic [2:0] COL_FALL    = 3'b110
) (
  input logic              clk_50,
  input logic              reset,
  board_renderer_if.slave  bus
);

  localparam int LAST_ROW = 22;
  localparam int LAST_COL = 9;

  typedef enum logic [1:0] {IDLE, LATCH, DRAW, DONE} state_t;

  state_t       state;
  logic [229:0] snap_board;
  logic [3:0]   snap_x [4];
  logic [4:0]   snap_y [4];

  logic [4:0]   row;
  logic [3:0]   col;
  logic [2:0]   py;
  logic [2:0]   px;

  logic         px_last;
  logic         py_last;
  logic         col_last;
  logic         frame_last;
  logic         fall_hit;
  logic [7:0]   bit_idx;
  logic [2:0]   pix_colour;
  logic [7:0]   pix_x;
  logic [6:0]   pix_y;

  logic [7:0]   vga_x_q;
  logic [6:0]   vga_y_q;
  logic [2:0]   colour_q;
  logic         plot_q;
  logic         busy_q;
  logic         done_q;

  assign bus.vga_x  = vga_x_q;
  assign bus.vga_y  = vga_y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

  // Detect the end of each sweep level; frame_last marks the very last pixel.
  always_comb begin
    px_last    = (int'(px) == TILE_PX - 1);
    py_last    = (int'(py) == TILE_PX - 1);
    col_last   = (int'(col) == LAST_COL);
    frame_last = (int'(row) == LAST_ROW) && col_last && py_last && px_last;
  end

  // Pixel address and colour for the current counters; falling tiles beat stacked ones.
  always_comb begin
    fall_hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if ((snap_x[k] == col) && (snap_y[k] == row)) begin
        fall_hit = 1'b1;
      end
    end
    bit_idx = 8'(int'(row) * 10 + 9 - int'(col));
    if (fall_hit) begin
      pix_colour = COL_FALL;
    end else if (snap_board[bit_idx]) begin
      pix_colour = COL_STACK;
    end else begin
      pix_colour = COL_EMPTY;
    end
    pix_x = 8'(X_ORIGIN + int'(col) * TILE_PX + int'(px));
    pix_y = 7'(Y_ORIGIN + (int'(row) - HIDDEN_ROWS) * TILE_PX + int'(py));
  end

  // Frame FSM: snapshot, counter sweep and registered pixel/status outputs.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      snap_board <= '0;
      for (int k = 0; k < 4; k++) begin
        snap_x[k] <= '0;
        snap_y[k] <= '0;
      end
      row      <= '0;
      col      <= '0;
      py       <= '0;
      px       <= '0;
      vga_x_q  <= '0;
      vga_y_q  <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      plot_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            snap_board <= bus.board_value;
            snap_x[0]  <= bus.t0_x;
            snap_x[1]  <= bus.t1_x;
            snap_x[2]  <= bus.t2_x;
            snap_x[3]  <= bus.t3_x;
            snap_y[0]  <= bus.t0_y;
            snap_y[1]  <= bus.t1_y;
            snap_y[2]  <= bus.t2_y;
            snap_y[3]  <= bus.t3_y;
            busy_q     <= 1'b1;
            state      <= LATCH;
          end
        end
        LATCH: begin
          row   <= 5'(HIDDEN_ROWS);
          col   <= '0;
          py    <= '0;
          px    <= '0;
          state <= DRAW;
        end
        DRAW: begin
          vga_x_q  <= pix_x;
          vga_y_q  <= pix_y;
          colour_q <= pix_colour;
          plot_q   <= 1'b1;
          if (px_last) begin
            px <= '0;
            if (py_last) begin
              py <= '0;
              if (col_last) begin
                col <= '0;
                row <= row + 5'd1;
              end else begin
                col <= col + 4'd1;
              end
            end else begin
              py <= py + 3'd1;
            end
          end else begin
            px <= px + 3'd1;
          end
          if (frame_last) begin
            state <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Testbench for board_renderer: table of board/piece set-ups with hand-computed pixel
// counts and probe colours, plus hand-written sequences for mid-frame start, mid-frame
// reset and back-to-back frames.
module tb_board_renderer;

  logic clk_50 = 1'b0;
  logic reset;

  always #10 clk_50 = ~clk_50;

  board_renderer_if bus ();

  board_renderer dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .bus    (bus)
  );

  typedef struct {
    int bitIdx;
    int t0x, t0y, t1x, t1y, t2x, t2y, t3x, t3y;
    bit midChange;
    int n111, n110;
    int probeX, probeY, probeCol;
  } vec_t;

  vec_t vecs [6];

  int total = 0;
  int bad   = 0;

  int plots, dones, n111, n110, addrErr, probeSeen, firstLat, doneGap;
  int lastX, lastY, gapLen, extraPlots, extraDones;
  bit finished;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk_50);
    bus.board_value = '0;
    if (v.bitIdx >= 0) bus.board_value[v.bitIdx] = 1'b1;
    bus.t0_x = 4'(v.t0x);
    bus.t0_y = 5'(v.t0y);
    bus.t1_x = 4'(v.t1x);
    bus.t1_y = 5'(v.t1y);
    bus.t2_x = 4'(v.t2x);
    bus.t2_y = 5'(v.t2y);
    bus.t3_x = 4'(v.t3x);
    bus.t3_y = 5'(v.t3y);
  endtask

  // Pulse start, then watch one frame to its done pulse, tallying pixels.
  task automatic runFrame(input bit midChange, input bit midStart, input int probeX, input int probeY);
    int lastPlotCyc;
    int idx, r, c, ppy, ppx, ex, ey;
    plots = 0; dones = 0; n111 = 0; n110 = 0; addrErr = 0;
    probeSeen = -1; firstLat = -1; doneGap = -1; lastX = -1; lastY = -1;
    finished = 1'b0;
    lastPlotCyc = -1;
    @(negedge clk_50);
    bus.start = 1'b1;
    @(negedge clk_50);
    bus.start = 1'b0;
    checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
    for (int cyc = 1; cyc <= 4000 && !finished; cyc++) begin
      @(negedge clk_50);
      if (bus.plot) begin
        if (plots == 0) firstLat = cyc;
        idx = plots;
        ppx = idx % 4;
        ppy = (idx / 4) % 4;
        c   = (idx / 16) % 10;
        r   = 3 + idx / 160;
        ex  = 40 + 4 * c + ppx;
        ey  = 10 + 4 * (r - 3) + ppy;
        if (bus.vga_x !== 8'(ex) || bus.vga_y !== 7'(ey)) addrErr++;
        if (bus.colour == 3'b111) n111++;
        if (bus.colour == 3'b110) n110++;
        if (int'(bus.vga_x) == probeX && int'(bus.vga_y) == probeY) probeSeen = int'(bus.colour);
        lastX = int'(bus.vga_x);
        lastY = int'(bus.vga_y);
        plots++;
        lastPlotCyc = cyc;
        if (midChange && plots == 100) bus.board_value = '1;
      end
      bus.start = midStart && bus.plot && (plots == 100);
      if (bus.done) begin
        dones++;
        if (doneGap < 0) doneGap = cyc - lastPlotCyc;
      end else if (dones > 0) begin
        finished = 1'b1;
      end
    end
    bus.start = 1'b0;
    checkOutput("frame_finished", 32'(finished), 32'd1);
  endtask

  // Count any plots or done pulses over a quiet window.
  task automatic watchQuiet(input int cycles);
    extraPlots = 0;
    extraDones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_50);
      if (bus.plot) extraPlots++;
      if (bus.done) extraDones++;
    end
  endtask

  initial begin
    vecs[0] = '{-1,  0, 0,  0, 0,  0,  0,  0,  0, 1'b0,  0,  0, 40, 10, 0};
    vecs[1] = '{229, 0, 0,  0, 0,  0,  0,  0,  0, 1'b0, 16,  0, 40, 86, 7};
    vecs[2] = '{30,  9, 3,  0, 0,  0,  0,  0,  0, 1'b0,  0, 16, 79, 13, 6};
    vecs[3] = '{229, 4, 0,  4, 1,  5,  1,  5,  2, 1'b1, 16,  0, 56, 10, 0};
    vecs[4] = '{107, 12, 5, 3, 25, 2, 10, 15, 31, 1'b0,  0, 16, 48, 38, 6};
    vecs[5] = '{39,  0, 22, 0, 0,  0,  0,  0,  0, 1'b0, 16, 16, 40, 10, 7};

    bus.start = 1'b0;
    bus.board_value = '0;
    bus.t0_x = '0; bus.t1_x = '0; bus.t2_x = '0; bus.t3_x = '0;
    bus.t0_y = '0; bus.t1_y = '0; bus.t2_y = '0; bus.t3_y = '0;
    reset = 1'b1;
    #1;
    checkOutput("rst_plot",   32'(bus.plot),   32'd0);
    checkOutput("rst_busy",   32'(bus.busy),   32'd0);
    checkOutput("rst_done",   32'(bus.done),   32'd0);
    checkOutput("rst_vga_x",  32'(bus.vga_x),  32'd0);
    checkOutput("rst_vga_y",  32'(bus.vga_y),  32'd0);
    checkOutput("rst_colour", 32'(bus.colour), 32'd0);
    repeat (3) @(negedge clk_50);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      runFrame(vecs[i].midChange, 1'b0, vecs[i].probeX, vecs[i].probeY);
      checkOutput($sformatf("v%0d_plots", i),    32'(plots),     32'd3200);
      checkOutput($sformatf("v%0d_dones", i),    32'(dones),     32'd1);
      checkOutput($sformatf("v%0d_first_lat", i), 32'(firstLat), 32'd2);
      checkOutput($sformatf("v%0d_done_gap", i), 32'(doneGap),   32'd1);
      checkOutput($sformatf("v%0d_addr_err", i), 32'(addrErr),   32'd0);
      checkOutput($sformatf("v%0d_last_x", i),   32'(lastX),     32'd79);
      checkOutput($sformatf("v%0d_last_y", i),   32'(lastY),     32'd89);
      checkOutput($sformatf("v%0d_n111", i),     32'(n111),      32'(vecs[i].n111));
      checkOutput($sformatf("v%0d_n110", i),     32'(n110),      32'(vecs[i].n110));
      checkOutput($sformatf("v%0d_probe", i),    32'(probeSeen), 32'(vecs[i].probeCol));
      checkOutput($sformatf("v%0d_idle_busy", i), 32'(bus.busy), 32'd0);
    end

    // Start re-pulsed mid-frame must be dropped, not queued.
    applyStimulus(vecs[0]);
    runFrame(1'b0, 1'b1, 40, 10);
    checkOutput("midstart_plots", 32'(plots), 32'd3200);
    checkOutput("midstart_dones", 32'(dones), 32'd1);
    watchQuiet(20);
    checkOutput("midstart_no_requeue", 32'(extraPlots), 32'd0);

    // Reset at the 500th plot aborts the frame at once.
    applyStimulus(vecs[1]);
    @(negedge clk_50);
    bus.start = 1'b1;
    @(negedge clk_50);
    bus.start = 1'b0;
    plots = 0;
    for (int cyc = 0; cyc < 1000 && plots < 500; cyc++) begin
      @(negedge clk_50);
      if (bus.plot) plots++;
    end
    checkOutput("rstmid_reached_500", 32'(plots), 32'd500);
    reset = 1'b1;
    #1;
    checkOutput("rstmid_plot",  32'(bus.plot),  32'd0);
    checkOutput("rstmid_busy",  32'(bus.busy),  32'd0);
    checkOutput("rstmid_vga_x", 32'(bus.vga_x), 32'd0);
    checkOutput("rstmid_vga_y", 32'(bus.vga_y), 32'd0);
    @(negedge clk_50);
    reset = 1'b0;
    watchQuiet(200);
    checkOutput("rstmid_no_plots", 32'(extraPlots), 32'd0);
    checkOutput("rstmid_no_done",  32'(extraDones), 32'd0);
    checkOutput("rstmid_colour",   32'(bus.colour), 32'd0);

    // Start held high gives two back-to-back frames with a three-cycle gap.
    applyStimulus(vecs[0]);
    @(negedge clk_50);
    bus.start = 1'b1;
    plots = 0; dones = 0; gapLen = -1;
    begin
      int lastPlotCyc;
      bit prevPlot;
      lastPlotCyc = -1;
      prevPlot = 1'b0;
      for (int cyc = 0; cyc < 8000 && dones < 2; cyc++) begin
        @(negedge clk_50);
        if (bus.plot) begin
          if (!prevPlot && plots > 0 && gapLen < 0) gapLen = cyc - lastPlotCyc - 1;
          plots++;
          lastPlotCyc = cyc;
        end
        prevPlot = bus.plot;
        if (bus.done) dones++;
      end
    end
    bus.start = 1'b0;
    checkOutput("b2b_plots", 32'(plots),  32'd6400);
    checkOutput("b2b_dones", 32'(dones),  32'd2);
    checkOutput("b2b_gap",   32'(gapLen), 32'd3);
    watchQuiet(20);
    checkOutput("b2b_stops", 32'(extraPlots), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
